// File: rtl/dep_output_arbiter_if.sv
// Requester/output bundle for dep_output_arbiter.
// The lock vector exists only when DEP_ARB_LOCK_EN is defined.
interface dep_output_arbiter_if #(
  parameter int N      = 3,
  parameter int DATA_W = 1
);
  logic [N-1:0]        req;
  logic [N*DATA_W-1:0] din;
`ifdef DEP_ARB_LOCK_EN
  logic [N-1:0]        lock;
`endif
  logic                out_ready;
  logic [N-1:0]        gnt;
  logic [N-1:0]        ack;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;

`ifdef DEP_ARB_LOCK_EN
  modport master (output req, din, lock, out_ready,
                  input  gnt, ack, out_valid, out_data);
  modport slave  (input  req, din, lock, out_ready,
                  output gnt, ack, out_valid, out_data);
`else
  modport master (output req, din, out_ready,
                  input  gnt, ack, out_valid, out_data);
  modport slave  (input  req, din, out_ready,
                  output gnt, ack, out_valid, out_data);
`endif
endinterface

// File: rtl/dep_output_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output among N requesters.
// Optional DEP_ARB_LOCK_EN: a granted requester holding lock is not cut off at MAX_HOLD.
module dep_output_arbiter #(
  parameter int N        = 3,
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input logic                 clk,
  input logic                 rst,
  dep_output_arbiter_if.slave arb
);
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [IW-1:0]     last_q, last_d;
  logic [7:0]        hold_cnt_q, hold_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic [IW-1:0]     pick;
  logic              found;
  logic              accept;
  logic              lock_g;
  logic [7:0]        hold_inc;

  // last_q doubles as the granted index while in GRANT
  assign accept   = (state_q == GRANT) && arb.req[last_q] && (!out_valid_q || arb.out_ready);
  assign hold_inc = (hold_cnt_q >= 8'(MAX_HOLD)) ? 8'(MAX_HOLD) : hold_cnt_q + 8'd1;

`ifdef DEP_ARB_LOCK_EN
  assign lock_g = arb.lock[last_q];
`else
  assign lock_g = 1'b0;
`endif

  for (genvar i = 0; i < N; i++) begin : g_ack
    assign arb.ack[i] = accept && (last_q == IW'(i));
  end

  assign arb.gnt       = gnt_q;
  assign arb.out_valid = out_valid_q;
  assign arb.out_data  = out_data_q;

  // Rotating priority: first requester after the previous winner
  always_comb begin
    int idx;
    idx   = 0;
    pick  = last_q;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (!found && arb.req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    hold_cnt_d  = hold_cnt_q;
    out_valid_d = out_valid_q & ~arb.out_ready;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = GRANT;
          gnt_d      = {{(N-1){1'b0}}, 1'b1} << pick;
          last_d     = pick;
          hold_cnt_d = 8'd0;
        end
      end
      GRANT: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = arb.din[last_q*DATA_W +: DATA_W];
          hold_cnt_d  = hold_inc;
        end
        if (!arb.req[last_q] || (accept && hold_inc >= 8'(MAX_HOLD) && !lock_g)) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      last_q      <= IW'(N-1);
      hold_cnt_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      hold_cnt_q  <= hold_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule

// File: tb/tb_dep_output_arbiter.sv
// Bench for dep_output_arbiter: two instances (MAX_HOLD 4 and 1) on shared stimulus,
// each compared every cycle against a rule-level reference model.
module tb_dep_output_arbiter;
  localparam int N  = 3;
  localparam int DW = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  lock;
  logic [N*DW-1:0] din;
  logic          out_ready;

  int checks   = 0;
  int failures = 0;

  dep_output_arbiter_if #(.N(N), .DATA_W(DW)) if0 ();
  dep_output_arbiter_if #(.N(N), .DATA_W(DW)) if1 ();

  assign if0.req = req;  assign if0.din = din;  assign if0.out_ready = out_ready;
  assign if1.req = req;  assign if1.din = din;  assign if1.out_ready = out_ready;
`ifdef DEP_ARB_LOCK_EN
  assign if0.lock = lock;
  assign if1.lock = lock;
`endif

  dep_output_arbiter #(.N(N), .DATA_W(DW), .MAX_HOLD(4)) u0 (.clk(clk), .rst(rst), .arb(if0));
  dep_output_arbiter #(.N(N), .DATA_W(DW), .MAX_HOLD(1)) u1 (.clk(clk), .rst(rst), .arb(if1));

  logic [N-1:0]  g [2];
  logic [N-1:0]  a [2];
  logic          ov[2];
  logic [DW-1:0] od[2];
  assign g[0] = if0.gnt;  assign a[0] = if0.ack;  assign ov[0] = if0.out_valid;  assign od[0] = if0.out_data;
  assign g[1] = if1.gnt;  assign a[1] = if1.ack;  assign ov[1] = if1.out_valid;  assign od[1] = if1.out_data;

  // Reference model: owner = granted requester or -1, beats = accepts in this grant
  int            m_owner[2];
  int            m_last [2];
  int            m_beats[2];
  logic          m_ov   [2];
  logic [DW-1:0] m_od   [2];
  int            mh     [2] = '{4, 1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1; m_last[k] = N - 1; m_beats[k] = 0; m_ov[k] = 1'b0; m_od[k] = '0;
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_gnt%0d", tag, k), 32'(g[k]), 32'd0);
      check($sformatf("%s_ack%0d", tag, k), 32'(a[k]), 32'd0);
      check($sformatf("%s_ov%0d",  tag, k), 32'(ov[k]), 32'd0);
    end
  endtask

  // Compare instance k with the model for the current cycle, then advance the model one edge
  task automatic cmp_adv(input int k);
    logic [N-1:0] eg, ea;
    logic         acc, lk;
    eg  = (m_owner[k] >= 0) ? N'(1 << m_owner[k]) : '0;
    acc = (m_owner[k] >= 0) && req[m_owner[k]] && (!m_ov[k] || out_ready);
    ea  = acc ? eg : '0;
`ifdef DEP_ARB_LOCK_EN
    lk = (m_owner[k] >= 0) && lock[m_owner[k]];
`else
    lk = 1'b0;
`endif
    check($sformatf("gnt%0d", k),  32'(g[k]),  32'(eg));
    check($sformatf("ack%0d", k),  32'(a[k]),  32'(ea));
    check($sformatf("oval%0d", k), 32'(ov[k]), 32'(m_ov[k]));
    check($sformatf("odat%0d", k), 32'(od[k]), 32'(m_od[k]));

    if (m_owner[k] < 0) begin
      if (out_ready) m_ov[k] = 1'b0;
      for (int j = 1; j <= N; j++) begin
        int i;
        i = (m_last[k] + j) % N;
        if (req[i]) begin
          m_owner[k] = i; m_last[k] = i; m_beats[k] = 0;
          break;
        end
      end
    end else begin
      int o;
      o = m_owner[k];
      if (acc) begin
        m_od[k] = din[o*DW +: DW];
        m_ov[k] = 1'b1;
        if (m_beats[k] < mh[k]) m_beats[k]++;
      end else if (out_ready) begin
        m_ov[k] = 1'b0;
      end
      if (!req[o] || (acc && m_beats[k] == mh[k] && !lk)) m_owner[k] = -1;
    end
  endtask

  // Called at a falling edge; leaves at the next falling edge
  task automatic step(input logic [N-1:0] r, input logic o, input logic [N-1:0] l);
    req = r; out_ready = o; lock = l; din = N*DW'($urandom);
    #1;
    cmp_adv(0);
    cmp_adv(1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req = '0; lock = '0; din = '0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_zero("reset");
    check("reset_odat0", 32'(od[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // All requesting: 4-beat bursts rotating 0,1,2 with an idle cycle between
    repeat (18) step(3'b111, 1'b1, 3'b000);
    repeat (2)  step(3'b000, 1'b1, 3'b000);

    // Short request from requester 1
    repeat (2)  step(3'b010, 1'b1, 3'b000);
    repeat (3)  step(3'b000, 1'b1, 3'b000);

    // Backpressure after the first accept of requester 0
    repeat (2)  step(3'b001, 1'b1, 3'b000);
    repeat (5)  step(3'b001, 1'b0, 3'b000);
    repeat (6)  step(3'b001, 1'b1, 3'b000);
    repeat (2)  step(3'b000, 1'b1, 3'b000);

    // Asynchronous reset during the third beat of a burst
    repeat (3)  step(3'b111, 1'b1, 3'b000);
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (6)  step(3'b111, 1'b1, 3'b000);

    // Lone requester 2: MAX_HOLD=1 instance alternates grant and idle
    repeat (2)  step(3'b000, 1'b1, 3'b000);
    repeat (8)  step(3'b100, 1'b1, 3'b000);

`ifdef DEP_ARB_LOCK_EN
    repeat (3)  step(3'b000, 1'b1, 3'b000);
    repeat (11) step(3'b011, 1'b1, 3'b001);
    repeat (8)  step(3'b010, 1'b1, 3'b000);
`endif

    // Random traffic
    repeat (400) step(N'($urandom), ($urandom_range(3, 0) != 0), N'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
